// File: rtl/cfu_cmd_pkg.sv
// Shared types and constants for the CFU command sequencer.
package cfu_cmd_pkg;

  localparam int unsigned FID_W  = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CMD_W  = FID_W + 2 * DATA_W;

  // Operation codes carried in function_id[9:3]
  localparam logic [6:0] OP_LOAD_AB  = 7'd0;
  localparam logic [6:0] OP_START    = 7'd1;
  localparam logic [6:0] OP_READ_C   = 7'd2;
  localparam logic [6:0] OP_CLR_ACC  = 7'd3;
  localparam logic [6:0] OP_SIMD_MAC = 7'd4;

  typedef struct packed {
    logic [FID_W-1:0]  function_id;
    logic [DATA_W-1:0] inputs_0;
    logic [DATA_W-1:0] inputs_1;
  } cmd_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP
  } seq_state_t;

  function automatic logic [6:0] fid_op(input logic [FID_W-1:0] fid);
    return fid[9:3];
  endfunction

endpackage

// File: rtl/cfu_cmd_sequencer_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is a registered array entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_en, pop_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/cfu_cmd_sequencer.sv
// Issues queued CFU commands one at a time and collects their responses.
module cfu_cmd_sequencer
  import cfu_cmd_pkg::*;
#(
  parameter int unsigned CMD_DEPTH      = 16,
  parameter int unsigned RSP_DEPTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [9:0]  push_function_id,
  input  logic [31:0] push_inputs_0,
  input  logic [31:0] push_inputs_1,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_outputs_0,
  output logic        pop_valid,
  input  logic        pop_ready,
  output logic [31:0] pop_data,
  output logic        idle,
  output logic        err_timeout,
  input  logic        err_clear
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t     state_q, state_d;
  cmd_entry_t     push_entry, head_entry;
  cmd_entry_t     pay_q, pay_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           err_q, err_d;
  logic           cmd_full, cmd_empty, cmd_pop;
  logic           rsp_full, rsp_empty, rsp_push;

  assign push_entry = '{function_id: push_function_id,
                        inputs_0:    push_inputs_0,
                        inputs_1:    push_inputs_1};

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_valid),
    .data_i  (push_entry),
    .full_o  (cmd_full),
    .pop_i   (cmd_pop),
    .data_o  (head_entry),
    .empty_o (cmd_empty)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rsp_push),
    .data_i  (rsp_payload_outputs_0),
    .full_o  (rsp_full),
    .pop_i   (pop_ready),
    .data_o  (pop_data),
    .empty_o (rsp_empty)
  );

  always_comb begin
    state_d  = state_q;
    pay_d    = pay_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    cmd_pop  = 1'b0;
    rsp_push = 1'b0;
    if (err_clear) err_d = 1'b0;
    case (state_q)
      // Issue only with a free response slot so the later write cannot overflow
      ST_IDLE: begin
        if (!cmd_empty && !rsp_full) begin
          cmd_pop = 1'b1;
          pay_d   = head_entry;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          tmo_d   = '0;
          state_d = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (tmo_q != TW'(TIMEOUT_CYCLES)) tmo_d = tmo_q + TW'(1);
        if (rsp_valid) begin
          rsp_push = 1'b1;
          state_d  = ST_IDLE;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pay_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pay_q   <= pay_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign cmd_valid               = (state_q == ST_ISSUE);
  assign rsp_ready               = (state_q == ST_WAIT_RSP);
  assign cmd_payload_function_id = pay_q.function_id;
  assign cmd_payload_inputs_0    = pay_q.inputs_0;
  assign cmd_payload_inputs_1    = pay_q.inputs_1;
  assign push_ready              = !cmd_full;
  assign pop_valid               = !rsp_empty;
  assign idle                    = (state_q == ST_IDLE) && cmd_empty && rsp_empty;
  assign err_timeout             = err_q;

endmodule

// File: tb/tb_cfu_cmd_sequencer.sv
// Scoreboard bench: a behavioural CFU answers in0+in1; pops are checked in order.
module tb_cfu_cmd_sequencer;

  localparam int unsigned CMD_DEPTH = 16;
  localparam int unsigned RSP_DEPTH = 16;
  localparam int unsigned TIMEOUT   = 1024;

  typedef struct packed {
    logic [9:0]  fid;
    logic [31:0] a;
    logic [31:0] b;
  } tcmd_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [9:0]  push_function_id = '0;
  logic [31:0] push_inputs_0 = '0;
  logic [31:0] push_inputs_1 = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid = 1'b0;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0 = '0;
  logic        pop_valid;
  logic        pop_ready = 1'b0;
  logic [31:0] pop_data;
  logic        idle;
  logic        err_timeout;
  logic        err_clear = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  tcmd_t       exp_cmd_q[$];
  logic [31:0] exp_rsp_q[$];

  // Mode knobs: 0 never, 1 always/immediate, 2 random
  int cmd_mode  = 1;
  int rsp_mode  = 1;
  int pop_mode  = 1;
  int pop_limit = 1 << 30;
  int cfu_fires = 0;
  int pops      = 0;

  logic        cfu_pend = 1'b0;
  logic [31:0] cfu_data = '0;
  int          cfu_delay = 0;
  tcmd_t       cfu_exp;

  always #5 clk = ~clk;

  cfu_cmd_sequencer #(
    .CMD_DEPTH      (CMD_DEPTH),
    .RSP_DEPTH      (RSP_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .push_valid              (push_valid),
    .push_ready              (push_ready),
    .push_function_id        (push_function_id),
    .push_inputs_0           (push_inputs_0),
    .push_inputs_1           (push_inputs_1),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .pop_valid               (pop_valid),
    .pop_ready               (pop_ready),
    .pop_data                (pop_data),
    .idle                    (idle),
    .err_timeout             (err_timeout),
    .err_clear               (err_clear)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic tcmd_t rand_cmd();
    tcmd_t c;
    c.fid = {7'($urandom_range(0, 4)), 3'($urandom_range(0, 7))};
    c.a   = $urandom;
    c.b   = $urandom;
    return c;
  endfunction

  // Reference CFU: checks issue order, then answers with in0+in1 after a delay
  always begin : cfu_model
    @(negedge clk);
    if (reset) begin
      cfu_pend = 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) cfu_pend = 1'b0;
      if (cmd_valid && cmd_ready) begin
        cfu_fires++;
        if (exp_cmd_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL cmd_unexpected: got fid 0x%03h, expected no command", cmd_payload_function_id);
        end else begin
          cfu_exp = exp_cmd_q.pop_front();
          check("cmd_fid", 32'(cmd_payload_function_id), 32'(cfu_exp.fid));
          check("cmd_in0", cmd_payload_inputs_0, cfu_exp.a);
          check("cmd_in1", cmd_payload_inputs_1, cfu_exp.b);
        end
        cfu_pend  = 1'b1;
        cfu_data  = cmd_payload_inputs_0 + cmd_payload_inputs_1;
        cfu_delay = (rsp_mode == 2) ? int'($urandom_range(0, 4)) : 0;
      end
    end
    @(posedge clk);
    #1;
    case (cmd_mode)
      0:       cmd_ready = 1'b0;
      1:       cmd_ready = 1'b1;
      default: cmd_ready = 1'($urandom_range(0, 1));
    endcase
    rsp_valid = 1'b0;
    if (cfu_pend && rsp_mode != 0) begin
      if (cfu_delay == 0) begin
        rsp_valid             = 1'b1;
        rsp_payload_outputs_0 = cfu_data;
      end else begin
        cfu_delay--;
      end
    end
  end

  always begin : pop_monitor
    @(negedge clk);
    if (!reset && pop_valid && pop_ready) begin
      pops++;
      if (exp_rsp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%08h, expected no response", pop_data);
      end else begin
        check("pop_data", pop_data, exp_rsp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    case (pop_mode)
      0:       pop_ready = 1'b0;
      1:       pop_ready = (pops < pop_limit);
      default: pop_ready = 1'($urandom_range(0, 1)) && (pops < pop_limit);
    endcase
  end

  task automatic push_cmd(input tcmd_t c, input int limit, output bit ok);
    ok = 1'b0;
    @(posedge clk);
    #1;
    push_valid       = 1'b1;
    push_function_id = c.fid;
    push_inputs_0    = c.a;
    push_inputs_1    = c.b;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (push_ready) begin
        ok = 1'b1;
        exp_cmd_q.push_back(c);
        exp_rsp_q.push_back(c.a + c.b);
        break;
      end
    end
    @(posedge clk);
    #1;
    push_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_cmd_q.size() == 0 && exp_rsp_q.size() == 0 && idle) begin
        done = 1'b1;
        break;
      end
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    bit    ok;
    bit    seen;
    bit    stable;
    int    f0;
    int    p0;
    int    acc;
    tcmd_t c;

    // Reset values
    @(negedge clk);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_rsp_ready", 32'(rsp_ready), 32'd0);
    check("rst_push_ready", 32'(push_ready), 32'd1);
    check("rst_pop_valid", 32'(pop_valid), 32'd0);
    check("rst_fid", 32'(cmd_payload_function_id), 32'd0);
    check("rst_in0", cmd_payload_inputs_0, 32'd0);
    check("rst_in1", cmd_payload_inputs_1, 32'd0);
    check("rst_pop_data", pop_data, 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single command, cycle-exact
    cmd_mode = 1; rsp_mode = 1; pop_mode = 1;
    c = '{fid: 10'h018, a: 32'd3, b: 32'd2};
    push_cmd(c, 50, ok);
    check("single_accept", 32'(ok), 32'd1);
    @(negedge clk);
    check("single_cmd_valid_n", 32'(cmd_valid), 32'd0);
    @(negedge clk);
    check("single_cmd_valid_n1", 32'(cmd_valid), 32'd1);
    check("single_fid_n1", 32'(cmd_payload_function_id), 32'h018);
    @(negedge clk);
    check("single_rsp_ready_n2", 32'(rsp_ready), 32'd1);
    check("single_pop_valid_n2", 32'(pop_valid), 32'd0);
    @(negedge clk);
    check("single_pop_valid_n3", 32'(pop_valid), 32'd1);
    check("single_pop_data_n3", pop_data, 32'd5);
    @(negedge clk);
    check("single_idle", 32'(idle), 32'd1);

    // Backpressure on the command channel
    cmd_mode = 0;
    f0 = cfu_fires;
    c = rand_cmd();
    push_cmd(c, 50, ok);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_valid_seen", 32'(seen), 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!cmd_valid || cmd_payload_function_id != c.fid ||
          cmd_payload_inputs_0 != c.a || cmd_payload_inputs_1 != c.b) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    check("bp_no_fire", 32'(cfu_fires - f0), 32'd0);
    cmd_mode = 1;
    drain("bp_drain");
    check("bp_one_fire", 32'(cfu_fires - f0), 32'd1);

    // Ordering under random delays on all channels
    cmd_mode = 2; rsp_mode = 2; pop_mode = 2;
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      c = rand_cmd();
      c.a = 32'h10 + 32'(i);
      c.b = '0;
      push_cmd(c, 200, ok);
    end
    drain("order_drain");
    check("order_pop_count", 32'(pops - p0), 32'd8);

    // Command queue full; one entry moves into the payload register on issue
    cmd_mode = 0; rsp_mode = 1; pop_mode = 1;
    pop_limit = pops;
    acc = 0;
    for (int i = 0; i < int'(CMD_DEPTH) + 2; i++) begin
      push_cmd(rand_cmd(), (i == int'(CMD_DEPTH) + 1) ? 4 : 50, ok);
      if (ok) acc++;
    end
    check("full_accepted", 32'(acc), 32'(CMD_DEPTH + 1));
    check("full_push_ready", 32'(push_ready), 32'd0);
    f0 = cfu_fires;
    cmd_mode = 1;
    repeat (150) @(negedge clk);
    check("full_stall_fires", 32'(cfu_fires - f0), 32'(RSP_DEPTH));
    check("full_stall_pop_valid", 32'(pop_valid), 32'd1);
    check("full_stall_cmd_valid", 32'(cmd_valid), 32'd0);
    check("full_stall_rsp_ready", 32'(rsp_ready), 32'd0);
    check("full_stall_idle", 32'(idle), 32'd0);
    pop_limit = pops + 1;
    repeat (20) @(negedge clk);
    check("full_resume_fires", 32'(cfu_fires - f0), 32'(CMD_DEPTH + 1));
    pop_limit = 1 << 30;
    drain("full_drain");

    // Random traffic
    cmd_mode = 2; rsp_mode = 2; pop_mode = 2;
    for (int i = 0; i < 30; i++) push_cmd(rand_cmd(), 200, ok);
    drain("rand_drain");

    // Timeout
    cmd_mode = 1; rsp_mode = 0; pop_mode = 1;
    push_cmd(rand_cmd(), 50, ok);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_fire_seen", 32'(seen), 32'd1);
    repeat (TIMEOUT) @(negedge clk);
    check("to_err_before", 32'(err_timeout), 32'd0);
    check("to_rsp_ready", 32'(rsp_ready), 32'd1);
    @(negedge clk);
    check("to_err_set", 32'(err_timeout), 32'd1);
    repeat (5) @(negedge clk);
    check("to_err_sticky", 32'(err_timeout), 32'd1);
    check("to_still_waiting", 32'(rsp_ready), 32'd1);
    rsp_mode = 1;
    drain("to_late_rsp");
    check("to_err_after_rsp", 32'(err_timeout), 32'd1);
    @(posedge clk);
    #1;
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    @(negedge clk);
    check("to_err_cleared", 32'(err_timeout), 32'd0);

    // Reset in WAIT_RSP with four commands queued
    cmd_mode = 1; rsp_mode = 0;
    for (int i = 0; i < 5; i++) push_cmd(rand_cmd(), 50, ok);
    @(negedge clk);
    check("rstop_in_wait", 32'(rsp_ready), 32'd1);
    f0 = cfu_fires;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstop_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rstop_rsp_ready", 32'(rsp_ready), 32'd0);
    check("rstop_idle", 32'(idle), 32'd1);
    check("rstop_pop_valid", 32'(pop_valid), 32'd0);
    check("rstop_push_ready", 32'(push_ready), 32'd1);
    exp_cmd_q.delete();
    exp_rsp_q.delete();
    rsp_mode = 1;
    repeat (10) @(negedge clk);
    check("rstop_no_reissue", 32'(cfu_fires - f0), 32'd0);
    check("rstop_pop_valid_later", 32'(pop_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
